rc4_stream_cipher: RTL and testbench

Parameterised RC4 cipher core that generalises the fixed-width `rc4_new_design` keystream block. It accepts keys up to `MAX_KEY_BYTES` bytes, runs the key schedule (KSA), and then XORs an input byte stream with the keystream at one byte per cycle. Both the input and the output use valid/ready handshakes. The core sits between the key-loading logic and the byte-stream datapath, and replaces one-shot batch keystream generation.

---
 rtl/rc4_stream_cipher_if.sv | 29 ++
 rtl/rc4_stream_cipher.sv | 222 ++++++++++++++++++++++
 tb/tb_rc4_stream_cipher.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_stream_cipher_if.sv
// rtl/rc4_stream_cipher_if.sv - byte stream handshake bundle for rc4_stream_cipher
// master drives the input stream and consumes the output stream; slave is the core.

interface rc4_stream_cipher_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/rc4_stream_cipher.sv
// rtl/rc4_stream_cipher.sv - RC4 core: key schedule, then XORs a byte stream with the keystream
// Optional RC4-drop[DROP_N] stage compiled in when RC4_DROP_EN is defined.

module rc4_stream_cipher #(
  parameter int MAX_KEY_BYTES = 16,
  parameter int DROP_N        = 768
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [MAX_KEY_BYTES*8-1:0] key,
  input  logic [8:0]                 key_length,
  rc4_stream_cipher_if.slave         strm,
  output logic                       done,
  output logic                       busy,
  output logic                       err
);

  localparam int KXW = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

  generate
    if (MAX_KEY_BYTES < 1 || MAX_KEY_BYTES > 256 || DROP_N < 0) begin : g_bad_cfg
      $error("rc4_stream_cipher: illegal MAX_KEY_BYTES or DROP_N");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
`ifdef RC4_DROP_EN
    ST_DROP,
`endif
    ST_PRGA
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       i_q, i_d;
  logic [7:0]       j_q, j_d;
  logic [KXW-1:0]   kx_q, kx_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       sbox_q [256];
  logic [7:0]       sbox_d [256];

`ifdef RC4_DROP_EN
  localparam int DCW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  logic [DCW-1:0]   drop_cnt_q, drop_cnt_d;
`endif

  logic [7:0] key_byte;
  logic       key_legal;
  logic       kx_wrap;
  logic       in_ready;
  logic       accept;

  logic [7:0] ksa_si, ksa_j, ksa_sj;
  logic [7:0] prga_i, prga_si, prga_j, prga_sj, prga_t, ks;

  assign key_byte  = 8'(key >> {kx_q, 3'b000});
  assign key_legal = (key_length != 9'd0) && (key_length <= 9'(MAX_KEY_BYTES));
  assign kx_wrap   = (9'(kx_q) == (key_length - 9'd1));

  assign ksa_si = sbox_q[i_q];
  assign ksa_j  = j_q + ksa_si + key_byte;
  assign ksa_sj = sbox_q[ksa_j];

  // Keystream byte must see the post-swap S-box, so forward the two swapped entries.
  assign prga_i  = i_q + 8'd1;
  assign prga_si = sbox_q[prga_i];
  assign prga_j  = j_q + prga_si;
  assign prga_sj = sbox_q[prga_j];
  assign prga_t  = prga_si + prga_sj;
  assign ks      = (prga_t == prga_i) ? prga_sj :
                   (prga_t == prga_j) ? prga_si : sbox_q[prga_t];

  assign in_ready = (state_q == ST_PRGA) && (!out_valid_q || strm.out_ready);
  assign accept   = strm.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    kx_d        = kx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    sbox_d      = sbox_q;
`ifdef RC4_DROP_EN
    drop_cnt_d  = drop_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (key_legal) begin
            err_d   = 1'b0;
            state_d = ST_INIT;
          end else begin
            err_d   = 1'b1;
          end
        end
      end

      ST_INIT: begin
        for (int n = 0; n < 256; n++) begin
          sbox_d[n] = 8'(n);
        end
        i_d     = 8'd0;
        j_d     = 8'd0;
        kx_d    = '0;
        state_d = ST_KSA;
      end

      ST_KSA: begin
        j_d            = ksa_j;
        sbox_d[i_q]    = ksa_sj;
        sbox_d[ksa_j]  = ksa_si;
        i_d            = i_q + 8'd1;
        kx_d           = kx_wrap ? '0 : kx_q + KXW'(1);
        if (i_q == 8'd255) begin
          j_d = 8'd0;
`ifdef RC4_DROP_EN
          drop_cnt_d = '0;
          state_d    = (DROP_N > 0) ? ST_DROP : ST_PRGA;
`else
          state_d    = ST_PRGA;
`endif
        end
      end

`ifdef RC4_DROP_EN
      ST_DROP: begin
        i_d             = prga_i;
        j_d             = prga_j;
        sbox_d[prga_i]  = prga_sj;
        sbox_d[prga_j]  = prga_si;
        drop_cnt_d      = drop_cnt_q + DCW'(1);
        if (drop_cnt_q == DCW'(DROP_N - 1)) begin
          state_d = ST_PRGA;
        end
      end
`endif

      ST_PRGA: begin
        if (start) begin
          // Abort discards any byte still waiting for out_ready.
          out_valid_d = 1'b0;
          if (key_legal) begin
            err_d   = 1'b0;
            state_d = ST_INIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (accept) begin
          i_d             = prga_i;
          j_d             = prga_j;
          sbox_d[prga_i]  = prga_sj;
          sbox_d[prga_j]  = prga_si;
          out_valid_d     = 1'b1;
          out_data_d      = strm.in_data ^ ks;
        end else if (strm.out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_PRGA) && (state_q != ST_PRGA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      kx_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef RC4_DROP_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      kx_q        <= kx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef RC4_DROP_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  // S-box contents are rewritten in INIT, so it needs no reset.
  always_ff @(posedge clk) begin
    sbox_q <= sbox_d;
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign done           = done_q;
  assign err            = err_q;
`ifdef RC4_DROP_EN
  assign busy = (state_q == ST_INIT) || (state_q == ST_KSA) || (state_q == ST_DROP);
`else
  assign busy = (state_q == ST_INIT) || (state_q == ST_KSA);
`endif

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// tb/tb_rc4_stream_cipher.sv - randomized self-checking bench for rc4_stream_cipher
// Reference is a plain software RC4 model; RC4_DROP_EN shifts expected timing and keystream.

module tb_rc4_stream_cipher;

`ifdef RC4_DROP_EN
  localparam int DROP = 768;
`else
  localparam int DROP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [8:0]   key_length = 9'd0;
  logic         done, busy, err;

  rc4_stream_cipher_if bus();

  rc4_stream_cipher #(.MAX_KEY_BYTES(16), .DROP_N(768)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .key_length (key_length),
    .strm       (bus),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] ks_q[$];
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  logic [7:0] v1 [8] = '{8'hb2, 8'h39, 8'h63, 8'h05, 8'hf0, 8'h3d, 8'hc0, 8'h27};
  logic [7:0] v2 [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Software RC4: full KSA, DROP discarded bytes, then n keystream bytes.
  function automatic void model_ks(input logic [127:0] k, input int len, input int n);
    int s [256];
    int i, j, t;
    ks_q.delete();
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + int'(k[(x % len) * 8 +: 8])) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int x = 0; x < DROP + n; x++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (x >= DROP) ks_q.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endfunction

  task automatic load_key(input logic [127:0] k, input int len);
    int n;
    int busy_cyc;
    @(negedge clk);
    key = k;
    key_length = 9'(len);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    busy_cyc = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("start_clears_out_valid", bus.out_valid, 0);
        check("legal_start_clears_err", err, 0);
      end
      if (done) begin
        check("busy_low_at_done", busy, 0);
        break;
      end
      if (busy) busy_cyc++;
    end
    check("done_cycle", n, 258 + DROP);
    check("busy_cycles", busy_cyc, 257 + DROP);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic run_stream(input string tag, input int n, input int stall_at, input bit rnd);
    int sent = 0, got = 0, cyc = 0, stall = 0;
    bit stalled = 1'b0;
    logic pv = 1'b0, pr = 1'b1;
    logic [7:0] pd = 8'd0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (pv && !pr) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, pd);
      end
      if (stall_at >= 0 && !stalled && bus.out_valid && got == stall_at) begin
        stall = 5;
        stalled = 1'b1;
      end
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        stall--;
      end else begin
        bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = src_q[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_data", bus.out_data, exp_q[got]);
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        check(tag, bus.out_data, exp_q[got]);
        got++;
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (got < n) check("stream_timeout", got, n);
  endtask

  initial begin
    logic [71:0] pt;
    logic [127:0] rk;
    int len;
    int bad_len [2] = '{0, 17};

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Keystream vector with a 5-cycle output stall after byte 2
    load_key(128'h0504030201, 5);
    model_ks(128'h0504030201, 5, 8);
    src_q.delete(); exp_q.delete();
    for (int b = 0; b < 8; b++) begin
      src_q.push_back(8'd0);
      exp_q.push_back((DROP == 0) ? v1[b] : ks_q[b]);
    end
    run_stream("vec1_keystream", 8, 2, 1'b0);

    // Encryption vector
    load_key(128'h79654B, 3);
    model_ks(128'h79654B, 3, 9);
    pt = "Plaintext";
    src_q.delete(); exp_q.delete();
    for (int b = 0; b < 9; b++) begin
      src_q.push_back(pt[(8 - b) * 8 +: 8]);
      exp_q.push_back((DROP == 0) ? v2[b] : (pt[(8 - b) * 8 +: 8] ^ ks_q[b]));
    end
    run_stream("vec2_plaintext", 9, -1, 1'b0);

    // Leave a byte pending, then restart mid-PRGA
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'($urandom);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pending_before_abort", bus.out_valid, 1);
    load_key(128'h0504030201, 5);
    model_ks(128'h0504030201, 5, 8);
    src_q.delete(); exp_q.delete();
    for (int b = 0; b < 8; b++) begin
      src_q.push_back(8'd0);
      exp_q.push_back((DROP == 0) ? v1[b] : ks_q[b]);
    end
    run_stream("restart_keystream", 8, -1, 1'b1);

    // Illegal lengths: first from PRGA, then from IDLE
    foreach (bad_len[b]) begin
      @(negedge clk);
      key_length = 9'(bad_len[b]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("illegal_err", err, 1);
      check("illegal_busy", busy, 0);
      check("illegal_in_ready", bus.in_ready, 0);
      repeat (3) @(negedge clk);
      check("illegal_stays_idle", busy, 0);
    end

    // Random keys, including the shortest and longest lengths
    for (int s = 0; s < 5; s++) begin
      len = (s == 0) ? 1 : (s == 1) ? 16 : int'($urandom_range(1, 16));
      rk = {$urandom, $urandom, $urandom, $urandom};
      load_key(rk, len);
      model_ks(rk, len, 40);
      src_q.delete(); exp_q.delete();
      for (int b = 0; b < 40; b++) begin
        src_q.push_back(8'($urandom));
        exp_q.push_back(src_q[b] ^ ks_q[b]);
      end
      run_stream("random_stream", 40, -1, 1'b1);
    end

    // Asynchronous reset in the middle of KSA
    @(negedge clk);
    key_length = 9'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("ksa_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_err", err, 0);
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_in_ready", bus.in_ready, 0);
    check("async_rst_out_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
